gpr_wb_arbiter: RTL and testbench

- Owns the single write port (RegWr/rw/busW) of the 32x32 general-purpose register file.
- Shares that port between two requesters: pipeline writeback (A) and a long-latency unit such as mult/div (B).
- Keeps a scoreboard of registers with an outstanding B result and stalls decode on RAW/WAW hazards against them.
- Sits between the writeback stage, the long-latency unit and the register file.

---
 rtl/gpr_wb_arbiter_pkg.sv | 20 ++
 rtl/gpr_wb_arbiter_if.sv | 62 ++++++
 rtl/gpr_wb_arbiter_scoreboard.sv | 53 +++++
 rtl/gpr_wb_arbiter.sv | 93 +++++++++
 tb/tb_gpr_wb_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared definitions for the GPR write-port arbiter slice.
// Holds register-file geometry, the register index type and a one-hot
// helper used by the scoreboard.
package gpr_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  // Width of the B starvation counter; MAX_WAIT is limited to 1..15.
  localparam int WAIT_W     = 4;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  function automatic reg_mask_t reg_onehot(input reg_idx_t idx);
    return reg_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of every signal between the arbiter and its neighbours:
// writeback requester (A), long-latency result requester (B), the
// long-latency issue port, decode source lookups, the register-file
// write port, and debug visibility (pending scoreboard, wait counter).
//
// Handshake semantics (A, B and issue): a transfer happens on the posedge
// where valid and ready are both high. ready is a combinational function
// of the current valid and payload; valid never waits on ready. B must hold
// valid, b_rd and b_data stable until it sees b_ready.
//
// Modports: slave = arbiter side, master = environment side.
interface gpr_wb_arbiter_if;
  import gpr_wb_arbiter_pkg::*;

  logic                a_valid;
  logic                a_ready;
  reg_idx_t            a_rd;
  data_t               a_data;

  logic                b_valid;
  logic                b_ready;
  reg_idx_t            b_rd;
  data_t               b_data;

  logic                iss_valid;
  logic                iss_ready;
  reg_idx_t            iss_rd;

  reg_idx_t            rs;
  reg_idx_t            rt;
  logic                rs_used;
  logic                rt_used;
  logic                stall;

  logic                wr_en;
  reg_idx_t            wr_addr;
  data_t               wr_data;

  reg_mask_t           pending;
  logic [WAIT_W-1:0]   wait_cnt;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  iss_valid, iss_rd,
    input  rs, rt, rs_used, rt_used,
    output a_ready, b_ready, iss_ready, stall,
    output wr_en, wr_addr, wr_data,
    output pending, wait_cnt
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output iss_valid, iss_rd,
    output rs, rt, rs_used, rt_used,
    input  a_ready, b_ready, iss_ready, stall,
    input  wr_en, wr_addr, wr_data,
    input  pending, wait_cnt
  );

endinterface

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// gpr_scoreboard: one pending bit per GPR for results still owed by the
// long-latency unit, plus the three hazard lookups used by decode.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   set_en, set_idx    mark a register pending (issue accepted)
//   clr_en, clr_idx    clear a register (B result committed)
//   rs/rs_used, rt/rt_used  decode source lookups
//   chk_en, chk_idx    issue destination lookup (WAW)
//   hazard             any enabled lookup hits a pending register
//   pending            current scoreboard vector, bit 0 always 0
module gpr_scoreboard
  import gpr_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_idx_t  set_idx,
  input  logic      clr_en,
  input  reg_idx_t  clr_idx,
  input  reg_idx_t  rs,
  input  logic      rs_used,
  input  reg_idx_t  rt,
  input  logic      rt_used,
  input  logic      chk_en,
  input  reg_idx_t  chk_idx,
  output logic      hazard,
  output reg_mask_t pending
);

  reg_mask_t pending_d;

  // Clear is applied before set so distinct registers both take effect.
  // The same register is never set and cleared together because issue
  // is refused while its bit is pending.
  always_comb begin
    pending_d = pending;
    if (clr_en) pending_d = pending_d & ~reg_onehot(clr_idx);
    if (set_en) pending_d = pending_d | reg_onehot(set_idx);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_d;
  end

  always_comb begin
    hazard = (rs_used && pending[rs]) ||
             (rt_used && pending[rt]) ||
             (chk_en  && pending[chk_idx]);
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: owns the single register-file write port and shares it
// between pipeline writeback (A, normally preferred) and the long-latency
// unit (B). B is force-granted after losing MAX_WAIT consecutive cycles.
// Also tracks registers with outstanding B results and stalls decode on
// RAW/WAW hazards against them.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        gpr_wb_arbiter_if.slave: A/B/issue handshakes, decode
//              lookups, stall, wr_en/wr_addr/wr_data, pending, wait_cnt
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
)(
  input logic              clk,
  input logic              rst,
  gpr_wb_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic              force_b;
  logic              grant_a;
  logic              grant_b;
  logic              hazard;
  logic              iss_ok;
  logic [WAIT_W-1:0] wait_cnt;
  reg_idx_t          wr_addr;
  data_t             wr_data;
  reg_mask_t         pending;

  // Grants are masked by rst so nothing commits while reset is held,
  // even though the inputs may still be active.
  always_comb begin
    force_b = bus.b_valid && (wait_cnt == WAIT_LIMIT);
    grant_b = !rst && bus.b_valid && (!bus.a_valid || force_b);
    grant_a = !rst && bus.a_valid && !force_b;
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (grant_a) begin
      wr_addr = bus.a_rd;
      wr_data = bus.a_data;
    end else if (grant_b) begin
      wr_addr = bus.b_rd;
      wr_data = bus.b_data;
    end
  end

  // Counts consecutive cycles B was presented but not granted. A grant
  // happens at the limit, so the counter never passes MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              wait_cnt <= '0;
    else if (!bus.b_valid || grant_b)     wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIMIT)      wait_cnt <= wait_cnt + 1'b1;
  end

  // hazard already covers a pending issue destination.
  assign iss_ok = !rst && bus.iss_valid && !hazard;

  gpr_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_ok),
    .set_idx (bus.iss_rd),
    .clr_en  (grant_b),
    .clr_idx (bus.b_rd),
    .rs      (bus.rs),
    .rs_used (bus.rs_used),
    .rt      (bus.rt),
    .rt_used (bus.rt_used),
    .chk_en  (bus.iss_valid),
    .chk_idx (bus.iss_rd),
    .hazard  (hazard),
    .pending (pending)
  );

  always_comb begin
    bus.a_ready   = grant_a;
    bus.b_ready   = grant_b;
    bus.iss_ready = iss_ok;
    // A losing to a forced B must hold the pipeline.
    bus.stall     = rst || hazard || (bus.a_valid && !grant_a);
    bus.wr_en     = (grant_a || grant_b) && (wr_addr != '0);
    bus.wr_addr   = wr_addr;
    bus.wr_data   = wr_data;
    bus.pending   = pending;
    bus.wait_cnt  = wait_cnt;
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
  import gpr_wb_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;

  typedef struct {
    logic av; reg_idx_t ard; data_t ad;
    logic bv; reg_idx_t brd; data_t bd;
    logic iv; reg_idx_t ird;
    reg_idx_t rs; logic rsu; reg_idx_t rt; logic rtu;
    logic ear; logic ebr; logic eir; logic est; logic ewe;
    reg_idx_t ewa; data_t ewd; logic [31:0] epend; logic [3:0] ewait;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  gpr_wb_arbiter_if bus ();

  gpr_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Register file fed by the DUT write port, and the bench's expected copy.
  data_t rf_dut [NUM_REGS];
  data_t rf_exp [NUM_REGS];
  always @(posedge clk) if (bus.wr_en) rf_dut[bus.wr_addr] <= bus.wr_data;

  // Reference model state.
  logic [31:0] pend_m;
  int          losses;
  logic        b_act;
  reg_idx_t    b_rd_m;
  data_t       b_data_m;

  vec_t tbl [15];

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    bus.a_valid = v.av;  bus.a_rd = v.ard;   bus.a_data = v.ad;
    bus.b_valid = v.bv;  bus.b_rd = v.brd;   bus.b_data = v.bd;
    bus.iss_valid = v.iv; bus.iss_rd = v.ird;
    bus.rs = v.rs; bus.rs_used = v.rsu; bus.rt = v.rt; bus.rt_used = v.rtu;
  endtask

  task automatic cmp_outs(input vec_t v, input string tag);
    chk({tag, " a_ready"},   32'(bus.a_ready),   32'(v.ear));
    chk({tag, " b_ready"},   32'(bus.b_ready),   32'(v.ebr));
    chk({tag, " iss_ready"}, 32'(bus.iss_ready), 32'(v.eir));
    chk({tag, " stall"},     32'(bus.stall),     32'(v.est));
    chk({tag, " wr_en"},     32'(bus.wr_en),     32'(v.ewe));
    chk({tag, " wr_addr"},   32'(bus.wr_addr),   32'(v.ewa));
    chk({tag, " wr_data"},   bus.wr_data,        v.ewd);
    chk({tag, " pending"},   bus.pending,        v.epend);
    chk({tag, " wait_cnt"},  32'(bus.wait_cnt),  32'(v.ewait));
  endtask

  // One randomized cycle. Expectations come from the arbitration rules:
  // A wins unless B has already lost MAX_WAIT cycles in a row; decode
  // stalls on any use of a register still owed by B, or when A loses.
  task automatic rnd_step(input bit drain);
    vec_t v;
    reg_idx_t cand[$];
    logic hz, frc;
    v = '{default: 0};
    if (!b_act) begin
      for (int r = 1; r < NUM_REGS; r++) if (pend_m[r]) cand.push_back(reg_idx_t'(r));
      if (cand.size() > 0 && (drain || $urandom_range(0, 2) == 0)) begin
        b_act    = 1'b1;
        b_rd_m   = cand[$urandom_range(0, cand.size() - 1)];
        b_data_m = $urandom;
      end
    end
    if (!drain) begin
      v.av  = ($urandom_range(0, 3) != 0);
      v.ard = reg_idx_t'($urandom_range(0, 31));
      v.ad  = $urandom;
      v.iv  = ($urandom_range(0, 2) == 0);
      v.ird = reg_idx_t'($urandom_range(0, 7));
      v.rs  = reg_idx_t'($urandom_range(0, 7));
      v.rsu = 1'($urandom_range(0, 1));
      v.rt  = reg_idx_t'($urandom_range(0, 7));
      v.rtu = 1'($urandom_range(0, 1));
    end
    v.bv = b_act; v.brd = b_rd_m; v.bd = b_data_m;

    frc   = v.bv && (losses >= MAX_WAIT);
    v.ebr = v.bv && (!v.av || frc);
    v.ear = v.av && !frc;
    hz    = (v.rsu && pend_m[v.rs]) || (v.rtu && pend_m[v.rt]) || (v.iv && pend_m[v.ird]);
    v.eir = v.iv && !hz;
    v.est = hz || (v.av && !v.ear);
    if (v.ear)      begin v.ewa = v.ard; v.ewd = v.ad; end
    else if (v.ebr) begin v.ewa = v.brd; v.ewd = v.bd; end
    v.ewe   = (v.ear || v.ebr) && (v.ewa != 0);
    v.epend = pend_m;
    v.ewait = 4'(losses);

    set_in(v);
    #4;
    cmp_outs(v, drain ? "drain" : "rnd");
    if (v.ewe) rf_exp[v.ewa] = v.ewd;
    if (v.ebr) begin pend_m[v.brd] = 1'b0; b_act = 1'b0; end
    if (v.eir && v.ird != 0) pend_m[v.ird] = 1'b1;
    losses = (v.bv && !v.ebr) ? losses + 1 : 0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t idle;
    vec_t v;
    bit   drained;
    idle = '{default: 0};
    for (int r = 0; r < NUM_REGS; r++) begin rf_dut[r] = '0; rf_exp[r] = '0; end
    pend_m = '0; losses = 0; b_act = 1'b0; b_rd_m = '0; b_data_m = '0;
    set_in(idle);

    // Reset state.
    #12;
    chk("rst stall",   32'(bus.stall),   32'd1);
    chk("rst wr_en",   32'(bus.wr_en),   32'd0);
    chk("rst pending", bus.pending,      32'd0);
    chk("rst wait",    32'(bus.wait_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table: av ard ad bv brd bd iv ird rs rsu rt rtu |
    //                 ear ebr eir est ewe ewa ewd epend ewait
    tbl[0]  = '{1,4,32'h1234, 0,0,0, 0,0, 0,0,0,0,  1,0,0,0,1, 4,32'h1234, 32'h0, 0};
    tbl[1]  = '{0,0,0, 0,0,0, 1,8, 0,0,0,0,         0,0,1,0,0, 0,0, 32'h0, 0};
    tbl[2]  = '{0,0,0, 0,0,0, 0,0, 8,1,0,0,         0,0,0,1,0, 0,0, 32'h100, 0};
    tbl[3]  = '{0,0,0, 0,0,0, 1,8, 8,1,0,0,         0,0,0,1,0, 0,0, 32'h100, 0};
    tbl[4]  = '{0,0,0, 1,8,32'hBEEF, 1,8, 8,1,0,0,  0,1,0,1,1, 8,32'hBEEF, 32'h100, 0};
    tbl[5]  = '{0,0,0, 0,0,0, 1,8, 8,1,0,0,         0,0,1,0,0, 0,0, 32'h0, 0};
    tbl[6]  = '{0,0,0, 1,8,32'h55, 0,0, 0,0,8,0,    0,1,0,0,1, 8,32'h55, 32'h100, 0};
    tbl[7]  = '{1,0,32'hFFFF_FFFF, 0,0,0, 1,0, 0,0,0,0, 1,0,1,0,0, 0,32'hFFFF_FFFF, 32'h0, 0};
    tbl[8]  = '{0,0,0, 0,0,0, 0,0, 0,0,0,1,         0,0,0,0,0, 0,0, 32'h0, 0};
    for (int k = 0; k < 4; k++)
      tbl[9+k] = '{1,9,32'h900 + 32'(k), 1,10,32'hB0, 0,0, 0,0,0,0,
                   1,0,0,0,1, 9,32'h900 + 32'(k), 32'h0, 4'(k)};
    tbl[13] = '{1,9,32'h904, 1,10,32'hB0, 0,0, 0,0,0,0, 0,1,0,1,1, 10,32'hB0, 32'h0, 4};
    tbl[14] = '{1,9,32'h9FF, 0,0,0, 0,0, 0,0,0,0,   1,0,0,0,1, 9,32'h9FF, 32'h0, 0};

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i]);
      #4;
      cmp_outs(tbl[i], $sformatf("tbl%0d", i));
      if (tbl[i].ewe) rf_exp[tbl[i].ewa] = tbl[i].ewd;
      @(posedge clk); #1;
      if (i == 0) chk("r4 after A write", rf_dut[4], 32'h1234);
      if (i == 4) chk("r8 after B commit", rf_dut[8], 32'hBEEF);
    end
    chk("r0 untouched", rf_dut[0], 32'h0);
    chk("r9 last A",    rf_dut[9], 32'h9FF);
    chk("r10 forced B", rf_dut[10], 32'hB0);

    // Randomized traffic, then drain outstanding B results.
    for (int n = 0; n < 400; n++) rnd_step(1'b0);
    drained = 1'b0;
    for (int n = 0; n < 200 && !drained; n++) begin
      if (pend_m == 0 && !b_act) drained = 1'b1;
      else rnd_step(1'b1);
    end
    chk("drain bound", 32'(drained), 32'd1);
    for (int r = 0; r < NUM_REGS; r++) chk($sformatf("rf r%0d", r), rf_dut[r], rf_exp[r]);

    // Asynchronous reset with pending r3,r5 and B waiting two cycles.
    v = idle; v.iv = 1; v.ird = 3; set_in(v); @(posedge clk); #1;
    v.ird = 5;                     set_in(v); @(posedge clk); #1;
    v = idle; v.av = 1; v.ard = 11; v.ad = 32'h1111; v.bv = 1; v.brd = 3; v.bd = 32'h3333;
    set_in(v); @(posedge clk); #1;
    rf_exp[11] = 32'h1111;
    @(posedge clk); #1;
    v.iv = 1; v.ird = 7; set_in(v);
    #1;
    chk("pre-rst pending", bus.pending, 32'h28);
    chk("pre-rst wait",    32'(bus.wait_cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("arst pending",   bus.pending,        32'h0);
    chk("arst wait",      32'(bus.wait_cnt),  32'd0);
    chk("arst a_ready",   32'(bus.a_ready),   32'd0);
    chk("arst b_ready",   32'(bus.b_ready),   32'd0);
    chk("arst iss_ready", 32'(bus.iss_ready), 32'd0);
    chk("arst wr_en",     32'(bus.wr_en),     32'd0);
    chk("arst wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("arst wr_data",   bus.wr_data,        32'h0);
    chk("arst stall",     32'(bus.stall),     32'd1);
    @(posedge clk); #1;
    chk("rst held wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst held stall", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    set_in(idle);
    for (int n = 0; n < 3; n++) begin
      #4;
      chk("post-rst wr_en",   32'(bus.wr_en), 32'd0);
      chk("post-rst stall",   32'(bus.stall), 32'd0);
      chk("post-rst pending", bus.pending,    32'h0);
      @(posedge clk); #1;
    end
    chk("r3 not written",  rf_dut[3],  rf_exp[3]);
    chk("r5 not written",  rf_dut[5],  rf_exp[5]);
    chk("r11 A writes",    rf_dut[11], rf_exp[11]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
